// File: rtl/graphics_sequencer.sv
// graphics_sequencer
// Decodes byte-oriented drawing commands into palette updates, rectangle
// fills and frame-buffer swap requests.
//
// Ports:
//   clock_in, reset_in             system clock, async active-high reset
//   op_code_in / op_code_valid_in  command opcode, valid for the whole command
//   operand_in / operand_valid_in  operand byte with one-cycle strobe
//   operand_count_in               0-based slot index of the strobed operand
//   pixel_write_*                  frame-buffer write port (enable/ready handshake)
//   switch_write_buffer_out        one-cycle buffer swap pulse
//   assign_color_*                 palette write strobe, entry and YCbCr value
//   busy_out                       high while a rectangle is being set up or filled
//   dropped_out                    sticky flag: a command was discarded while busy
module graphics_sequencer #(
   parameter int DISPLAY_WIDTH  = 640,
   parameter int DISPLAY_HEIGHT = 400
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic [7:0]  op_code_in,
   input  logic        op_code_valid_in,
   input  logic [7:0]  operand_in,
   input  logic        operand_valid_in,
   input  logic [31:0] operand_count_in,
   output logic [17:0] pixel_write_address_out,
   output logic [3:0]  pixel_write_data_out,
   output logic        pixel_write_enable_out,
   input  logic        pixel_write_buffer_ready_in,
   output logic        switch_write_buffer_out,
   output logic        assign_color_enable_out,
   output logic [3:0]  assign_color_index_out,
   output logic [9:0]  assign_color_value_out,
   output logic        busy_out,
   output logic        dropped_out
);

   localparam logic [7:0]  OP_ASSIGN = 8'h11;
   localparam logic [7:0]  OP_FILL   = 8'h12;
   localparam logic [7:0]  OP_SHOW   = 8'h17;
   localparam logic [31:0] WIDTH_W   = 32'(DISPLAY_WIDTH);
   localparam logic [31:0] HEIGHT_W  = 32'(DISPLAY_HEIGHT);
   localparam logic [17:0] WIDTH_A   = 18'(DISPLAY_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_SETUP,
      ST_FILL
   } state_t;

   state_t      state_q, state_d;
   logic        op_valid_prev_q;
   logic [7:0]  opcode_q, opcode_d;
   logic [7:0]  operands_q [0:8];
   logic [7:0]  operands_d [0:8];
   logic        complete_q, complete_d;
   logic        pending_show_q, pending_show_d;
   logic        dropped_q, dropped_d;
   logic        switch_q, switch_d;
   logic        color_en_q, color_en_d;
   logic [3:0]  color_idx_q, color_idx_d;
   logic [9:0]  color_val_q, color_val_d;
   logic        pix_en_q, pix_en_d;
   logic [17:0] pix_addr_q, pix_addr_d;
   logic [3:0]  pix_data_q, pix_data_d;
   logic [17:0] row_start_q, row_start_d;
   logic [15:0] col_q, col_d;
   logic [15:0] row_q, row_d;
   logic [15:0] w_lim_q, w_lim_d;
   logic [15:0] h_lim_q, h_lim_d;

   logic        opcode_edge;
   logic        busy;
   logic        finishing;
   logic        accept;
   logic        last_col;
   logic        last_row;
   logic [15:0] fill_x, fill_y, fill_w, fill_h;
   logic [31:0] x_room, y_room;
   logic [15:0] w_clip, h_clip;
   logic        fill_empty;
   logic [17:0] start_addr;

   // Number of operand bytes each known opcode expects; unknown opcodes
   // accept none, so all their operands fall on the floor.
   function automatic logic [31:0] operand_total(input logic [7:0] op);
      case (op)
         OP_ASSIGN: operand_total = 32'd4;
         OP_FILL:   operand_total = 32'd9;
         default:   operand_total = 32'd0;
      endcase
   endfunction

   // op_valid_prev_q resets high so a valid already asserted when reset
   // releases is not mistaken for a new command.
   assign opcode_edge = op_code_valid_in && !op_valid_prev_q;
   assign busy        = (state_q == ST_SETUP) || (state_q == ST_FILL);

   // Rectangle geometry decoded from the big-endian operand pairs.
   assign fill_x     = {operands_q[0], operands_q[1]};
   assign fill_y     = {operands_q[2], operands_q[3]};
   assign fill_w     = {operands_q[4], operands_q[5]};
   assign fill_h     = {operands_q[6], operands_q[7]};
   assign x_room     = WIDTH_W - 32'(fill_x);
   assign y_room     = HEIGHT_W - 32'(fill_y);
   assign w_clip     = (32'(fill_w) < x_room) ? fill_w : x_room[15:0];
   assign h_clip     = (32'(fill_h) < y_room) ? fill_h : y_room[15:0];
   assign fill_empty = (fill_w == 16'd0) || (fill_h == 16'd0) ||
                       (32'(fill_x) >= WIDTH_W) || (32'(fill_y) >= HEIGHT_W);
   assign start_addr = 18'(32'(fill_y) * WIDTH_W + 32'(fill_x));

   assign accept   = pix_en_q && pixel_write_buffer_ready_in;
   assign last_col = (col_q == w_lim_q - 16'd1);
   assign last_row = (row_q == h_lim_q - 16'd1);

   // Next-state and output logic. Pulses default low; everything else holds.
   always_comb begin
      state_d        = state_q;
      opcode_d       = opcode_q;
      operands_d     = operands_q;
      complete_d     = complete_q;
      pending_show_d = pending_show_q;
      dropped_d      = dropped_q;
      switch_d       = 1'b0;
      color_en_d     = 1'b0;
      color_idx_d    = color_idx_q;
      color_val_d    = color_val_q;
      pix_en_d       = pix_en_q;
      pix_addr_d     = pix_addr_q;
      pix_data_d     = pix_data_q;
      row_start_d    = row_start_q;
      col_d          = col_q;
      row_d          = row_q;
      w_lim_d        = w_lim_q;
      h_lim_d        = h_lim_q;
      finishing      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (opcode_edge) begin
               if (op_code_in == OP_SHOW) begin
                  switch_d = 1'b1;
               end else begin
                  opcode_d   = op_code_in;
                  complete_d = 1'b0;
                  state_d    = ST_COLLECT;
               end
            end
         end

         ST_COLLECT: begin
            // Completion is acted on the cycle after the final operand lands,
            // so the command runs even if valid drops right after it.
            if (complete_q) begin
               complete_d = 1'b0;
               if (opcode_q == OP_ASSIGN) begin
                  color_en_d  = 1'b1;
                  color_idx_d = operands_q[0][3:0];
                  color_val_d = {operands_q[1][3:0], operands_q[2][2:0], operands_q[3][2:0]};
                  state_d     = ST_IDLE;
               end else if (opcode_q == OP_FILL) begin
                  state_d = ST_SETUP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (!op_code_valid_in) begin
               state_d = ST_IDLE;
            end else if (operand_valid_in && (operand_count_in < operand_total(opcode_q))) begin
               operands_d[operand_count_in[3:0]] = operand_in;
               if (operand_count_in == operand_total(opcode_q) - 32'd1) begin
                  complete_d = 1'b1;
               end
            end
         end

         ST_SETUP: begin
            if (fill_empty) begin
               finishing = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               pix_en_d    = 1'b1;
               pix_addr_d  = start_addr;
               row_start_d = start_addr;
               pix_data_d  = operands_q[8][3:0];
               col_d       = 16'd0;
               row_d       = 16'd0;
               w_lim_d     = w_clip;
               h_lim_d     = h_clip;
               state_d     = ST_FILL;
            end
         end

         ST_FILL: begin
            // The address only moves on an accepted write; a row end jumps
            // straight to the next row start so no bubble cycle is inserted.
            if (accept) begin
               if (last_col) begin
                  if (last_row) begin
                     pix_en_d  = 1'b0;
                     finishing = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     row_start_d = row_start_q + WIDTH_A;
                     pix_addr_d  = row_start_q + WIDTH_A;
                     col_d       = 16'd0;
                     row_d       = row_q + 16'd1;
                  end
               end else begin
                  pix_addr_d = pix_addr_q + 18'd1;
                  col_d      = col_q + 16'd1;
               end
            end
         end

         default: begin
            state_d  = ST_IDLE;
            pix_en_d = 1'b0;
         end
      endcase

      // While busy, a show request is remembered (repeats merge into one)
      // and anything else is thrown away. The remembered show fires as the
      // fill finishes, including the case where it arrives on that very cycle.
      if (busy) begin
         if (opcode_edge) begin
            if (op_code_in == OP_SHOW) begin
               pending_show_d = 1'b1;
            end else begin
               dropped_d = 1'b1;
            end
         end
         if (finishing) begin
            switch_d       = pending_show_d;
            pending_show_d = 1'b0;
         end
      end
   end

   // State register; the async reset kills an in-progress fill at once.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q         <= ST_IDLE;
         op_valid_prev_q <= 1'b1;
         opcode_q        <= 8'h00;
         operands_q      <= '{default: 8'h00};
         complete_q      <= 1'b0;
         pending_show_q  <= 1'b0;
         dropped_q       <= 1'b0;
         switch_q        <= 1'b0;
         color_en_q      <= 1'b0;
         color_idx_q     <= 4'h0;
         color_val_q     <= 10'h000;
         pix_en_q        <= 1'b0;
         pix_addr_q      <= 18'h00000;
         pix_data_q      <= 4'h0;
         row_start_q     <= 18'h00000;
         col_q           <= 16'h0000;
         row_q           <= 16'h0000;
         w_lim_q         <= 16'h0000;
         h_lim_q         <= 16'h0000;
      end else begin
         state_q         <= state_d;
         op_valid_prev_q <= op_code_valid_in;
         opcode_q        <= opcode_d;
         operands_q      <= operands_d;
         complete_q      <= complete_d;
         pending_show_q  <= pending_show_d;
         dropped_q       <= dropped_d;
         switch_q        <= switch_d;
         color_en_q      <= color_en_d;
         color_idx_q     <= color_idx_d;
         color_val_q     <= color_val_d;
         pix_en_q        <= pix_en_d;
         pix_addr_q      <= pix_addr_d;
         pix_data_q      <= pix_data_d;
         row_start_q     <= row_start_d;
         col_q           <= col_d;
         row_q           <= row_d;
         w_lim_q         <= w_lim_d;
         h_lim_q         <= h_lim_d;
      end
   end

   assign pixel_write_address_out = pix_addr_q;
   assign pixel_write_data_out    = pix_data_q;
   assign pixel_write_enable_out  = pix_en_q;
   assign switch_write_buffer_out = switch_q;
   assign assign_color_enable_out = color_en_q;
   assign assign_color_index_out  = color_idx_q;
   assign assign_color_value_out  = color_val_q;
   assign busy_out                = busy;
   assign dropped_out             = dropped_q;

endmodule

// File: tb/tb_graphics_sequencer.sv
// tb_graphics_sequencer
// Self-checking bench for graphics_sequencer. A negedge monitor logs every
// accepted pixel write, swap pulse and palette strobe; expected results come
// from a simple rectangle model that enumerates the pixels of the requested
// rectangle and keeps the ones that land on screen.
module tb_graphics_sequencer;

   localparam int W = 640;
   localparam int H = 400;

   logic        clock_in = 1'b0;
   logic        reset_in;
   logic [7:0]  op_code_in;
   logic        op_code_valid_in;
   logic [7:0]  operand_in;
   logic        operand_valid_in;
   logic [31:0] operand_count_in;
   logic [17:0] pixel_write_address_out;
   logic [3:0]  pixel_write_data_out;
   logic        pixel_write_enable_out;
   logic        pixel_write_buffer_ready_in;
   logic        switch_write_buffer_out;
   logic        assign_color_enable_out;
   logic [3:0]  assign_color_index_out;
   logic [9:0]  assign_color_value_out;
   logic        busy_out;
   logic        dropped_out;

   always #5 clock_in = ~clock_in;

   graphics_sequencer #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
      .clock_in                    (clock_in),
      .reset_in                    (reset_in),
      .op_code_in                  (op_code_in),
      .op_code_valid_in            (op_code_valid_in),
      .operand_in                  (operand_in),
      .operand_valid_in            (operand_valid_in),
      .operand_count_in            (operand_count_in),
      .pixel_write_address_out     (pixel_write_address_out),
      .pixel_write_data_out        (pixel_write_data_out),
      .pixel_write_enable_out      (pixel_write_enable_out),
      .pixel_write_buffer_ready_in (pixel_write_buffer_ready_in),
      .switch_write_buffer_out     (switch_write_buffer_out),
      .assign_color_enable_out     (assign_color_enable_out),
      .assign_color_index_out      (assign_color_index_out),
      .assign_color_value_out      (assign_color_value_out),
      .busy_out                    (busy_out),
      .dropped_out                 (dropped_out)
   );

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int viol = 0;
   int ready_mode = 0;
   int got_addr[$];
   int got_data[$];
   int got_cyc[$];
   int sw_cyc[$];
   int col_log[$];
   int exp_addr[$];

   // Monitor: outputs are sampled mid-cycle, well away from the rising edge.
   always @(negedge clock_in) begin
      cyc++;
      if (!reset_in) begin
         if (pixel_write_enable_out && !busy_out) viol++;
         if (pixel_write_address_out > 18'(W * H - 1)) viol++;
         if (pixel_write_enable_out && pixel_write_buffer_ready_in) begin
            got_addr.push_back(int'(pixel_write_address_out));
            got_data.push_back(int'(pixel_write_data_out));
            got_cyc.push_back(cyc);
         end
         if (switch_write_buffer_out) sw_cyc.push_back(cyc);
         if (assign_color_enable_out)
            col_log.push_back(int'({assign_color_index_out, assign_color_value_out}));
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock_in);
      #1;
      case (ready_mode)
         0:       pixel_write_buffer_ready_in = 1'b1;
         1:       pixel_write_buffer_ready_in = ~pixel_write_buffer_ready_in;
         default: pixel_write_buffer_ready_in = 1'($urandom_range(0, 1));
      endcase
   endtask

   // One command transaction: raise valid, strobe nsend operands with a
   // quiet cycle between them, hold a little longer, then drop valid.
   task automatic applyStimulus(input logic [7:0] op, input int nsend,
                                input logic [71:0] bytes, output int raise_cyc);
      raise_cyc        = cyc;
      op_code_in       = op;
      op_code_valid_in = 1'b1;
      step();
      for (int i = 0; i < nsend; i++) begin
         operand_in       = bytes[8*i +: 8];
         operand_count_in = 32'(i);
         operand_valid_in = 1'b1;
         step();
         operand_valid_in = 1'b0;
         step();
      end
      step();
      step();
      op_code_valid_in = 1'b0;
      step();
   endtask

   function automatic logic [71:0] fill_bytes(input int x, input int y, input int w,
                                              input int h, input int color);
      logic [71:0] b;
      b[7:0]   = 8'(x >> 8);
      b[15:8]  = 8'(x);
      b[23:16] = 8'(y >> 8);
      b[31:24] = 8'(y);
      b[39:32] = 8'(w >> 8);
      b[47:40] = 8'(w);
      b[55:48] = 8'(h >> 8);
      b[63:56] = 8'(h);
      b[71:64] = 8'(color);
      return b;
   endfunction

   // Reference: every pixel of the rectangle in row-major order, keeping
   // only those that fall inside the display.
   task automatic model_fill(input int x, input int y, input int w, input int h);
      exp_addr.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            if ((x + c < W) && (y + r < H)) exp_addr.push_back((y + r) * W + x + c);
   endtask

   task automatic clear_logs();
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      sw_cyc.delete();
      col_log.delete();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy_out && n < budget) begin
         step();
         n++;
      end
      checkOutput("idle_timeout", 32'(busy_out), 32'd0);
      repeat (4) step();
   endtask

   task automatic check_fill(input int color, input bit consecutive);
      int n;
      checkOutput("write_count", got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         checkOutput("write_addr", got_addr[i], exp_addr[i]);
         checkOutput("write_data", got_data[i], color & 15);
         if (consecutive) checkOutput("write_cycle", got_cyc[i] - got_cyc[0], i);
      end
   endtask

   initial begin
      int rc;
      int x, y, w, h, color;
      int idx, yy, cb, cr;
      int n;
      int writes_at_reset;

      reset_in                    = 1'b1;
      op_code_in                  = 8'h00;
      op_code_valid_in            = 1'b0;
      operand_in                  = 8'h00;
      operand_valid_in            = 1'b0;
      operand_count_in            = 32'd0;
      pixel_write_buffer_ready_in = 1'b1;
      repeat (3) step();

      // Everything reads zero while reset is held.
      checkOutput("rst_enable", 32'(pixel_write_enable_out), 32'd0);
      checkOutput("rst_addr", 32'(pixel_write_address_out), 32'd0);
      checkOutput("rst_data", 32'(pixel_write_data_out), 32'd0);
      checkOutput("rst_switch", 32'(switch_write_buffer_out), 32'd0);
      checkOutput("rst_color_en", 32'(assign_color_enable_out), 32'd0);
      checkOutput("rst_color_val", 32'(assign_color_value_out), 32'd0);
      checkOutput("rst_busy", 32'(busy_out), 32'd0);
      checkOutput("rst_dropped", 32'(dropped_out), 32'd0);

      // A show already asserted when reset releases is not a new command.
      op_code_in       = 8'h17;
      op_code_valid_in = 1'b1;
      step();
      reset_in = 1'b0;
      repeat (5) step();
      checkOutput("no_edge_at_release", sw_cyc.size(), 0);
      op_code_valid_in = 1'b0;
      step();

      // Palette assignment with the documented example.
      clear_logs();
      applyStimulus(8'h11, 4, {40'h0, 8'h02, 8'h05, 8'h0F, 8'h03}, rc);
      repeat (2) step();
      checkOutput("color_count", col_log.size(), 1);
      checkOutput("color_word", (col_log.size() > 0) ? col_log[0] : -1, (3 << 10) | 10'h3EA);

      // Random palette assignments.
      for (int k = 0; k < 3; k++) begin
         clear_logs();
         idx = $urandom_range(0, 255);
         yy  = $urandom_range(0, 255);
         cb  = $urandom_range(0, 255);
         cr  = $urandom_range(0, 255);
         applyStimulus(8'h11, 4, {40'h0, 8'(cr), 8'(cb), 8'(yy), 8'(idx)}, rc);
         repeat (2) step();
         checkOutput("rnd_color_count", col_log.size(), 1);
         checkOutput("rnd_color_word", (col_log.size() > 0) ? col_log[0] : -1,
                     ((idx % 16) << 10) + (yy % 16) * 64 + (cb % 8) * 8 + (cr % 8));
      end

      // Small fill, ready always high: back-to-back writes.
      ready_mode = 0;
      clear_logs();
      model_fill(2, 1, 3, 2);
      applyStimulus(8'h12, 9, fill_bytes(2, 1, 3, 2, 7), rc);
      wait_idle(200);
      checkOutput("fill_first_addr", (got_addr.size() > 0) ? got_addr[0] : -1, 642);
      check_fill(7, 1'b1);

      // Same fill with ready toggling: order kept, each write held.
      ready_mode = 1;
      clear_logs();
      applyStimulus(8'h12, 9, fill_bytes(2, 1, 3, 2, 7), rc);
      wait_idle(200);
      check_fill(7, 1'b0);

      // Clipping at the bottom-right corner, then fully off-screen cases.
      ready_mode = 0;
      clear_logs();
      model_fill(638, 399, 10, 10);
      applyStimulus(8'h12, 9, fill_bytes(638, 399, 10, 10, 9), rc);
      wait_idle(200);
      checkOutput("corner_count", got_addr.size(), 2);
      check_fill(9, 1'b1);
      clear_logs();
      applyStimulus(8'h12, 9, fill_bytes(640, 0, 4, 4, 1), rc);
      wait_idle(200);
      applyStimulus(8'h12, 9, fill_bytes(0, 400, 4, 4, 1), rc);
      wait_idle(200);
      applyStimulus(8'h12, 9, fill_bytes(5, 5, 0, 4, 1), rc);
      wait_idle(200);
      checkOutput("offscreen_writes", got_addr.size(), 0);

      // Random rectangles, biased towards the screen edges, random ready.
      ready_mode = 2;
      for (int k = 0; k < 8; k++) begin
         clear_logs();
         x = ($urandom_range(0, 1) == 1) ? $urandom_range(0, W + 4) : $urandom_range(W - 8, W + 2);
         y = ($urandom_range(0, 1) == 1) ? $urandom_range(0, H + 4) : $urandom_range(H - 8, H + 2);
         w = $urandom_range(0, 12);
         h = $urandom_range(0, 12);
         color = $urandom_range(0, 255);
         model_fill(x, y, w, h);
         applyStimulus(8'h12, 9, fill_bytes(x, y, w, h, color), rc);
         wait_idle(2000);
         check_fill(color, 1'b0);
      end

      // Commands during a fill: shows merge into one pulse after the last
      // write, the palette command is dropped.
      ready_mode = 0;
      clear_logs();
      model_fill(0, 10, 10, 3);
      applyStimulus(8'h12, 9, fill_bytes(0, 10, 10, 3, 5), rc);
      applyStimulus(8'h17, 0, 72'h0, rc);
      applyStimulus(8'h17, 0, 72'h0, rc);
      applyStimulus(8'h11, 4, {40'h0, 8'h01, 8'h02, 8'h03, 8'h04}, rc);
      checkOutput("busy_during_cmds", 32'(busy_out), 32'd1);
      wait_idle(500);
      check_fill(5, 1'b1);
      checkOutput("busy_switch_count", sw_cyc.size(), 1);
      checkOutput("busy_switch_cycle", (sw_cyc.size() > 0) ? sw_cyc[0] : -1,
                  (got_cyc.size() > 0) ? got_cyc[got_cyc.size() - 1] + 1 : -2);
      checkOutput("busy_dropped", 32'(dropped_out), 32'd1);
      checkOutput("busy_no_color", col_log.size(), 0);

      // Aborted fill, unknown opcode, then a normal show.
      clear_logs();
      applyStimulus(8'h12, 5, fill_bytes(1, 1, 4, 4, 3), rc);
      repeat (4) step();
      applyStimulus(8'h55, 3, {48'h0, 8'h12, 8'h34, 8'h56}, rc);
      repeat (4) step();
      checkOutput("abort_writes", got_addr.size(), 0);
      checkOutput("abort_busy", 32'(busy_out), 32'd0);
      checkOutput("abort_color", col_log.size(), 0);
      checkOutput("abort_switch", sw_cyc.size(), 0);
      applyStimulus(8'h17, 0, 72'h0, rc);
      repeat (2) step();
      checkOutput("show_count", sw_cyc.size(), 1);
      checkOutput("show_cycle", (sw_cyc.size() > 0) ? sw_cyc[0] : -1, rc + 2);
      checkOutput("dropped_sticky", 32'(dropped_out), 32'd1);

      // Reset in the middle of a fill stops writes at once.
      clear_logs();
      applyStimulus(8'h12, 9, fill_bytes(0, 0, 40, 4, 6), rc);
      n = 0;
      while (got_addr.size() < 5 && n < 200) begin
         step();
         n++;
      end
      checkOutput("fill_started", 32'(got_addr.size() >= 5), 32'd1);
      writes_at_reset = got_addr.size();
      reset_in = 1'b1;
      #1;
      checkOutput("midfill_rst_enable", 32'(pixel_write_enable_out), 32'd0);
      checkOutput("midfill_rst_busy", 32'(busy_out), 32'd0);
      checkOutput("midfill_rst_dropped", 32'(dropped_out), 32'd0);
      repeat (2) step();
      reset_in = 1'b0;
      repeat (10) step();
      checkOutput("midfill_no_more_writes", got_addr.size(), writes_at_reset);
      checkOutput("midfill_idle", 32'(busy_out), 32'd0);

      checkOutput("enable_addr_violations", viol, 0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
